// File: rtl/mux16_arbiter.sv
// Round-robin arbiter and select sequencer in front of the shared mux16.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD grant cycles.
module mux16_arbiter #(
    parameter int R = 16,
    parameter int J = 3
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 15
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [R-1:0] req,
    input  logic [R-1:0] done,
    output logic [R-1:0] gnt,
    output logic [J:0]   opc,
    output logic         valid,
    output logic         busy,
    output logic         timeout
);

    localparam int W = J + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [W-1:0]   opc_q, opc_d;
    logic [R-1:0]   gnt_q, gnt_d;
    logic           timeout_q, timeout_d;
    logic [W-1:0]   win;
    logic [W-1:0]   idx;
    logic           win_ok;
    logic           rel;
    logic           force_rel;

    // First requester at or after ptr, wrapping through 15 back to 0
    always_comb begin
        win    = ptr_q;
        win_ok = 1'b0;
        idx    = ptr_q;
        for (int k = 0; k < R; k++) begin
            idx = ptr_q + W'(k);
            if (!win_ok && req[idx]) begin
                win    = idx;
                win_ok = 1'b1;
            end
        end
    end

    assign rel = done[opc_q] | ~req[opc_q];

`ifdef ARB_TIMEOUT_EN
    logic [W-1:0] hold_q, hold_d;

    assign force_rel = (hold_q == W'(MAX_HOLD - 1));

    always_comb begin
        hold_d = hold_q;
        unique case (state_q)
            IDLE:    if (win_ok) hold_d = '0;
            GRANT:   if (!rel) hold_d = hold_q + W'(1);
            default: hold_d = hold_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        opc_d     = opc_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (win_ok) begin
                    state_d = GRANT;
                    opc_d   = win;
                    gnt_d   = R'(1) << win;
                end
            end
            GRANT: begin
                // A normal release wins over a forced one
                if (rel || force_rel) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    ptr_d     = opc_q + W'(1);
                    timeout_d = !rel;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            opc_q     <= '0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            opc_q     <= opc_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign opc     = opc_q;
    assign valid   = (state_q == GRANT);
    assign busy    = (state_q == GRANT);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mux16_arbiter.sv
// Bench for mux16_arbiter: directed scenarios with literal expectations
// plus random traffic checked every cycle against a behavioural model.
module tb_mux16_arbiter;

    localparam int MAX_HOLD = 15;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] done;
    logic [15:0] gnt;
    logic [3:0]  opc;
    logic        valid;
    logic        busy;
    logic        timeout;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: owner index (-1 = none), search start, last select
    int m_own   = -1;
    int m_ptr   = 0;
    int m_opc   = 0;
    int m_held  = 0;
    bit m_to    = 0;
    bit m_known = 0;

    mux16_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .opc     (opc),
        .valid   (valid),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model update on every rising edge from the inputs seen there
    initial begin
        forever begin
            @(posedge clk);
            m_to = 0;
            if (!rst) begin
                m_own   = -1;
                m_ptr   = 0;
                m_opc   = 0;
                m_known = 1;
            end else if (m_own < 0) begin
                for (int k = 0; k < 16; k++) begin
                    if (m_own < 0 && req[(m_ptr + k) % 16]) begin
                        m_own = (m_ptr + k) % 16;
                    end
                end
                if (m_own >= 0) begin
                    m_opc  = m_own;
                    m_held = 0;
                end
            end else begin
                m_held++;
                if (done[m_own] || !req[m_own]) begin
                    m_ptr = (m_own + 1) % 16;
                    m_own = -1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (m_held == MAX_HOLD) begin
                    m_ptr = (m_own + 1) % 16;
                    m_own = -1;
                    m_to  = 1;
                end
`endif
            end
        end
    end

    // Compare DUT outputs to the model between edges
    initial begin
        forever begin
            @(negedge clk);
            if (m_known) begin
                chk("m_gnt", gnt, (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
                chk("m_opc", opc, m_opc);
                chk("m_valid", valid, m_own >= 0);
                chk("m_busy", busy, m_own >= 0);
                chk("m_timeout", timeout, m_to);
            end
        end
    end

    initial begin
        int cnt;
        rst  = 1'b0;
        req  = 16'hFFFF;
        done = 16'h0000;

        // Reset held with everyone requesting
        tick();
        tick();
        chk("rst_gnt", gnt, 16'h0000);
        chk("rst_opc", opc, 4'd0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        rst = 1'b1;
        tick();
        chk("first_gnt", gnt, 16'h0001);
        chk("first_opc", opc, 4'd0);

        // Single requester, release by done, pointer moves past 5
        req = 16'h0020;
        tick();
        chk("single_bubble", gnt, 16'h0000);
        tick();
        chk("single_gnt", gnt, 16'h0020);
        chk("single_opc", opc, 4'd5);
        chk("single_valid", valid, 1'b1);
        done = 16'h0020;
        tick();
        done = 16'h0000;
        chk("single_rel_gnt", gnt, 16'h0000);
        chk("single_rel_valid", valid, 1'b0);
        req = 16'h0021;
        tick();
        chk("ptr6_opc", opc, 4'd0);
        req = 16'h0000;
        tick();
        tick();

        // Round robin from a fresh pointer
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        req = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            cnt = 0;
            while (gnt == 16'h0000 && cnt < 20) begin
                tick();
                cnt++;
            end
            chk("rr_bubble", cnt, 1);
            chk("rr_opc", opc, i % 16);
            done = 16'd1 << (i % 16);
            tick();
            done = 16'h0000;
        end
        req = 16'h0000;
        tick();
        tick();

        // Pointer to 14, then wrap past 15 and ignore non-owner done
        req = 16'h2000;
        tick();
        chk("wrap_pre_opc", opc, 4'd13);
        req = 16'h0009;
        tick();
        tick();
        chk("wrap_opc", opc, 4'd0);
        chk("wrap_gnt", gnt, 16'h0001);
        done = 16'h0008;
        tick();
        done = 16'h0000;
        chk("ignore_gnt", gnt, 16'h0001);
        chk("ignore_valid", valid, 1'b1);
        req = 16'h0008;
        tick();
        tick();
        chk("next_opc", opc, 4'd3);
        chk("next_gnt", gnt, 16'h0008);
        req = 16'h0000;
        tick();
        tick();

        // Reset during a grant
        req = 16'h0080;
        tick();
        chk("mid_opc", opc, 4'd7);
        rst = 1'b0;
        req = 16'h0081;
        tick();
        chk("mid_rst_gnt", gnt, 16'h0000);
        chk("mid_rst_valid", valid, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_after_opc", opc, 4'd0);
        chk("mid_after_gnt", gnt, 16'h0001);
        req = 16'h0000;
        tick();
        tick();

`ifdef ARB_TIMEOUT_EN
        req = 16'h0004;
        tick();
        cnt = 0;
        while (gnt != 16'h0000 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("to_cycles", cnt, MAX_HOLD);
        chk("to_pulse", timeout, 1'b1);
        tick();
        chk("to_pulse_end", timeout, 1'b0);
        chk("to_regrant", opc, 4'd2);
        req = 16'h0000;
        tick();
        tick();
`endif

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) req = 16'($urandom);
            done = 16'($urandom & $urandom & $urandom);
            if (m_own >= 0 && $urandom_range(5) == 0) begin
                done = done | (16'd1 << m_own);
            end
            rst = ($urandom_range(199) != 0);
            tick();
        end
        rst  = 1'b1;
        req  = 16'h0000;
        done = 16'h0000;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
